// File: rtl/blackjack_pkg.sv
// Shared constants, shuffler state encoding and card helpers for the blackjack datapath.
package blackjack_pkg;

    localparam int DECK_SIZE = 52;
    localparam int CARD_W    = 6;
    localparam int RANK_W    = 4;

    localparam int               LFSR_W    = 8;
    // x^8+x^6+x^5+x^4+1 on a left-shifting register: feedback from bits 7,5,4,3
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        DRAW,
        SWAP,
        DEAL
    } shuf_state_e;

    function automatic logic [RANK_W-1:0] rank_of(input logic [CARD_W-1:0] c);
        return RANK_W'(c % CARD_W'(13)) + RANK_W'(1);
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load and step enable.
module lfsr8
    import blackjack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state
);

    logic fb;
    assign fb = ^(state & LFSR_TAPS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       state <= LFSR_W'(1);
        else if (load) state <= load_val;
        else if (step) state <= {state[LFSR_W-2:0], fb};
    end

endmodule

// File: rtl/deck_shuffler.sv
// Builds a 52-card deck (Fisher-Yates shuffle when SHUFFLER_RANDOM_EN is defined,
// plain order 0..51 otherwise) and deals one card per request with one-cycle latency.
module deck_shuffler
    import blackjack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CARD_W-1:0] seed,
    input  logic              shuffle_start,
    input  logic              deal_req,
    output logic              busy,
    output logic              ready,
    output logic              card_valid,
    output logic [CARD_W-1:0] card,
    output logic [RANK_W-1:0] card_rank,
    output logic [CARD_W-1:0] cards_left,
    output logic              deck_empty
);

    localparam logic [CARD_W-1:0] LAST = CARD_W'(DECK_SIZE - 1);
    localparam logic [CARD_W-1:0] FULL = CARD_W'(DECK_SIZE);

    shuf_state_e       state, state_nx;
    logic [CARD_W-1:0] deck [DECK_SIZE];
    logic [CARD_W-1:0] k, ptr;
    logic              deal_fire;

`ifdef SHUFFLER_RANDOM_EN
    logic [CARD_W-1:0] i_r, j_r, cand;
    logic [LFSR_W-1:0] lfsr_q;

    lfsr8 u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (shuffle_start),
        .step     (state == DRAW),
        .load_val ({2'b01, seed}),
        .state    (lfsr_q)
    );
    assign cand = lfsr_q[CARD_W-1:0];
`else
    logic unused_seed;
    assign unused_seed = ^seed;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: ;
`ifdef SHUFFLER_RANDOM_EN
            INIT: if (k == LAST) state_nx = DRAW;
            DRAW: if (cand <= i_r) state_nx = SWAP;
            SWAP: state_nx = (i_r == CARD_W'(1)) ? DEAL : DRAW;
`else
            INIT: if (k == LAST) state_nx = DEAL;
`endif
            DEAL: ;
            default: state_nx = IDLE;
        endcase
        // A new shuffle request overrides everything, including a pending deal.
        if (shuffle_start) state_nx = INIT;
    end

    assign busy       = (state == INIT) || (state == DRAW) || (state == SWAP);
    assign ready      = (state == DEAL);
    assign deck_empty = ready && (cards_left == '0);
    assign deal_fire  = ready && deal_req && !shuffle_start && (cards_left != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k          <= '0;
            ptr        <= '0;
            cards_left <= '0;
            card_valid <= 1'b0;
            card       <= '0;
            card_rank  <= '0;
`ifdef SHUFFLER_RANDOM_EN
            i_r        <= '0;
            j_r        <= '0;
`endif
        end else begin
            card_valid <= deal_fire;
            if (deal_fire) begin
                card       <= deck[ptr];
                card_rank  <= rank_of(deck[ptr]);
                ptr        <= ptr + CARD_W'(1);
                cards_left <= cards_left - CARD_W'(1);
            end
            if (shuffle_start) begin
                k          <= '0;
                cards_left <= '0;
`ifdef SHUFFLER_RANDOM_EN
                i_r        <= LAST;
`endif
            end else if (state == INIT) begin
                k <= k + CARD_W'(1);
            end
            if (state != DEAL && state_nx == DEAL) begin
                ptr        <= '0;
                cards_left <= FULL;
            end
`ifdef SHUFFLER_RANDOM_EN
            if (state == DRAW && cand <= i_r) j_r <= cand;
            if (state == SWAP)                i_r <= i_r - CARD_W'(1);
`endif
        end
    end

    // Deck storage carries no reset; its contents are only meaningful after INIT.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            deck[k] <= k;
`ifdef SHUFFLER_RANDOM_EN
        end else if (state == SWAP) begin
            deck[i_r] <= deck[j_r];
            deck[j_r] <= deck[i_r];
`endif
        end
    end

endmodule

// File: tb/tb_deck_shuffler.sv
// Scoreboard bench for deck_shuffler; covers both SHUFFLER_RANDOM_EN builds.
module tb_deck_shuffler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] seed = '0;
    logic       shuffle_start = 1'b0;
    logic       deal_req = 1'b0;
    logic       busy, ready, card_valid, deck_empty;
    logic [5:0] card, cards_left;
    logic [3:0] card_rank;

    deck_shuffler dut (
        .clk           (clk),
        .rst           (rst),
        .seed          (seed),
        .shuffle_start (shuffle_start),
        .deal_req      (deal_req),
        .busy          (busy),
        .ready         (ready),
        .card_valid    (card_valid),
        .card          (card),
        .card_rank     (card_rank),
        .cards_left    (cards_left),
        .deck_empty    (deck_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int card;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   dealt[$];
    int   run1[$];
    int   errs = 0, checks = 0, cyc = 0, model_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop one expectation per dealt card; a due expectation with no strobe is a gap.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (card_valid) begin
                dealt.push_back(int'(card));
                if (exp_q.size() == 0) begin
                    chk("unexpected_card", 1, 0);
                end else begin
                    e = exp_q.pop_front();
`ifdef SHUFFLER_RANDOM_EN
                    chk("card_range", int'(card < 6'd52), 1);
`else
                    chk("card", int'(card), e.card);
`endif
                    chk("rank", int'(card_rank), int'(card) % 13 + 1);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                chk("card_missing", 0, 1);
                e = exp_q.pop_front();
            end
        end
    end

    task automatic start(input logic [5:0] s);
        seed          = s;
        shuffle_start = 1'b1;
        model_left    = 0;
        tick();
        shuffle_start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_ready", int'(ready), 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 20000) begin
            tick();
            n++;
        end
        chk("ready_seen", int'(ready), 1);
        if (ready) model_left = 52;
    endtask

    task automatic deal_n(input int n);
        for (int i = 0; i < n; i++) begin
            deal_req = 1'b1;
            if (model_left > 0) begin
`ifdef SHUFFLER_RANDOM_EN
                exp_q.push_back('{card: -1, due: cyc + 1});
`else
                exp_q.push_back('{card: 52 - model_left, due: cyc + 1});
`endif
                model_left--;
            end
            tick();
        end
        deal_req = 1'b0;
        tick();
    endtask

    function automatic int count_unique();
        bit seen [52];
        int u = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        foreach (dealt[i]) begin
            if (dealt[i] >= 0 && dealt[i] < 52 && !seen[dealt[i]]) begin
                seen[dealt[i]] = 1'b1;
                u++;
            end
        end
        return u;
    endfunction

    function automatic int diffs_vs_run1();
        int d = 0;
        if (dealt.size() != run1.size()) return 99;
        foreach (dealt[i]) if (dealt[i] != run1[i]) d++;
        return d;
    endfunction

    initial begin
        // Reset held for 3 cycles with a shuffle request that must be ignored
        shuffle_start = 1'b1;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_card_valid", int'(card_valid), 0);
        chk("rst_card", int'(card), 0);
        chk("rst_card_rank", int'(card_rank), 0);
        chk("rst_cards_left", int'(cards_left), 0);
        chk("rst_deck_empty", int'(deck_empty), 0);
        shuffle_start = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_busy", int'(busy), 0);
        chk("idle_ready", int'(ready), 0);

        // Deal outside DEAL is dropped
        deal_n(2);

        // Full build and deal of 52 cards
        start(6'b001010);
        deal_n(3);
        wait_ready();
        chk("ready_busy", int'(busy), 0);
        chk("ready_cards_left", int'(cards_left), 52);
        chk("ready_empty", int'(deck_empty), 0);
        dealt.delete();
        deal_n(52);
        chk("full_count", dealt.size(), 52);
        chk("full_unique", count_unique(), 52);
        run1 = dealt;
        chk("after52_left", int'(cards_left), 0);
        chk("after52_empty", int'(deck_empty), 1);

        // 53rd request on an empty deck
        deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
        chk("empty_valid", int'(card_valid), 0);
        chk("empty_left", int'(cards_left), 0);
        chk("empty_flag", int'(deck_empty), 1);
        tick();

        // Restart after 10 cards, then a full deal from the rebuilt deck
        start(6'b001010);
        wait_ready();
        deal_n(10);
        chk("partial_left", int'(cards_left), 42);
        shuffle_start = 1'b1;
        model_left    = 0;
        tick();
        shuffle_start = 1'b0;
        chk("restart_ready", int'(ready), 0);
        chk("restart_left", int'(cards_left), 0);
        wait_ready();
        chk("rebuilt_left", int'(cards_left), 52);
        dealt.delete();
        deal_n(52);
        chk("same_seed_diffs", diffs_vs_run1(), 0);

        // Shuffle and deal in the same cycle: shuffle wins
        start(6'b001010);
        wait_ready();
        shuffle_start = 1'b1;
        deal_req      = 1'b1;
        model_left    = 0;
        tick();
        shuffle_start = 1'b0;
        deal_req      = 1'b0;
        chk("collide_valid", int'(card_valid), 0);
        chk("collide_ready", int'(ready), 0);
        chk("collide_busy", int'(busy), 1);

        // Reset in the middle of the build
`ifdef SHUFFLER_RANDOM_EN
        repeat (60) tick();
`else
        repeat (20) tick();
`endif
        chk("midbuild_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_ready", int'(ready), 0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_ready", int'(ready), 0);
        chk("post_rst_left", int'(cards_left), 0);

        // A different seed
        start(6'b000001);
        wait_ready();
        dealt.delete();
        deal_n(52);
        chk("seed1_unique", count_unique(), 52);
`ifdef SHUFFLER_RANDOM_EN
        chk("seed1_differs", int'(diffs_vs_run1() > 0), 1);
`else
        chk("seed1_in_order", diffs_vs_run1(), 0);
`endif
        chk("leftover_expect", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
